// File: rtl/exe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : exe_pkg
// Purpose  : Shared definitions for the execute-to-writeback stage:
//            ALU function codes, flag encodings, writeback entry type and
//            small decode helpers.
// Revision : 1.0 - initial release
// ============================================================================
package exe_pkg;

  // ALU function codes carried on CtrlFunc
  localparam logic [3:0] FN_AND   = 4'b0000;
  localparam logic [3:0] FN_OR    = 4'b0001;
  localparam logic [3:0] FN_XOR   = 4'b0010;
  localparam logic [3:0] FN_ADD   = 4'b0011;
  localparam logic [3:0] FN_SUB   = 4'b0100;
  localparam logic [3:0] FN_CMP   = 4'b0101;
  localparam logic [3:0] FN_NOT   = 4'b0110;
  localparam logic [3:0] FN_SHL16 = 4'b0111;
  localparam logic [3:0] FN_MUL   = 4'b1000;

  // ALU flag encodings
  localparam logic [1:0] FLG_POS  = 2'b00;
  localparam logic [1:0] FLG_ZERO = 2'b01;
  localparam logic [1:0] FLG_NEG  = 2'b10;

  // Widest register-file address the entry type can carry; the stage
  // zero-extends its REG_AW-bit address into this field.
  localparam int WB_AW_MAX = 8;

  typedef struct packed {
    logic [WB_AW_MAX-1:0] addr;
    logic [31:0]          data;
  } wb_entry_t;

  // Codes above FN_MUL are unassigned.
  function automatic logic fn_is_illegal(input logic [3:0] fn);
    return (fn > FN_MUL);
  endfunction

  // Everything legal except CMP produces a register write.
  function automatic logic fn_writes_reg(input logic [3:0] fn);
    return (fn != FN_CMP) && !fn_is_illegal(fn);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_skid_fifo.sv
`default_nettype none
// ============================================================================
// Module   : wb_skid_fifo
// Purpose  : Two-entry FIFO with a fixed head slot. entry0_q is always the
//            head, so the output is a plain register with no read mux.
// Ports    : clk, rst     - clock, synchronous active-high reset
//            push_i/din_i - write request and data (ignored when full)
//            pop_i        - read request (ignored when empty)
//            dout_o       - head entry
//            count_o      - occupancy 0..2
// Revision : 1.0 - initial release
// ============================================================================
module wb_skid_fifo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic [1:0]       count_o
);

  logic [WIDTH-1:0] entry0_q;
  logic [WIDTH-1:0] entry1_q;
  logic [1:0]       count_q;
  logic             do_push;
  logic             do_pop;

  assign do_push = push_i && (count_q != 2'd2);
  assign do_pop  = pop_i  && (count_q != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      entry0_q <= '0;
      entry1_q <= '0;
      count_q  <= 2'd0;
    end else begin
      if (do_pop) begin
        // Advance the tail into the head; at count 1 a simultaneous push
        // lands directly in the head slot.
        if (count_q == 2'd2) begin
          entry0_q <= entry1_q;
        end else if (do_push) begin
          entry0_q <= din_i;
        end
      end else if (do_push) begin
        if (count_q == 2'd0) begin
          entry0_q <= din_i;
        end else begin
          entry1_q <= din_i;
        end
      end
      count_q <= count_q + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  assign dout_o  = entry0_q;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/exe_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : exe_wb_stage
// Purpose  : Execute-to-writeback stage behind the 32-bit ALU. Register
//            writes are buffered in a 2-entry FIFO and drained to the
//            register file; CMP ops update the architectural flag register
//            that drives the branch-condition outputs.
// Ports    : clk, rst                 - clock, synchronous active-high reset
//            InValid/InReady          - ALU-side handshake
//            Result, Flags, CtrlFunc, RdAddr - ALU op fields
//            WbValid/WbReady, WbAddr, WbData - register-file write port
//            FlagReg, FlagValid, CondEq/Lt/Gt - flag state and decode
//            IllegalOp                - sticky illegal-code indicator
//            RetireCnt                - completed writeback count (wraps)
// Revision : 1.0 - initial release
// ============================================================================
module exe_wb_stage
  import exe_pkg::*;
#(
  parameter int REG_AW = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              InValid,
  output logic              InReady,
  input  logic [31:0]       Result,
  input  logic [1:0]        Flags,
  input  logic [3:0]        CtrlFunc,
  input  logic [REG_AW-1:0] RdAddr,
  output logic              WbValid,
  input  logic              WbReady,
  output logic [REG_AW-1:0] WbAddr,
  output logic [31:0]       WbData,
  output logic [1:0]        FlagReg,
  output logic              FlagValid,
  output logic              CondEq,
  output logic              CondLt,
  output logic              CondGt,
  output logic              IllegalOp,
  output logic [CNT_W-1:0]  RetireCnt
);

  localparam int ENTRY_W = $bits(wb_entry_t);

  logic             accept;
  logic             push;
  logic             pop;
  wb_entry_t        push_entry;
  wb_entry_t        head_entry;
  logic [1:0]       count;
  logic             unused_head_addr;

  logic [1:0]       flag_q;
  logic             flag_valid_q;
  logic             illegal_q;
  logic [CNT_W-1:0] retire_q;

  assign accept = InValid && InReady;
  assign push   = accept && fn_writes_reg(CtrlFunc);
  // Masking with rst keeps the register file from seeing a write while
  // buffered entries are being discarded.
  assign WbValid = (count != 2'd0) && !rst;
  assign pop     = WbValid && WbReady;
  assign InReady = (count != 2'd2);

  assign push_entry.addr = WB_AW_MAX'(RdAddr);
  assign push_entry.data = Result;

  wb_skid_fifo #(
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (push_entry),
    .pop_i   (pop),
    .dout_o  (head_entry),
    .count_o (count)
  );

  assign WbAddr = head_entry.addr[REG_AW-1:0];
  assign WbData = head_entry.data;
  // Upper address bits are always zero; fold them so they are not dangling.
  assign unused_head_addr = ^head_entry.addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      flag_q       <= FLG_POS;
      flag_valid_q <= 1'b0;
      illegal_q    <= 1'b0;
      retire_q     <= '0;
    end else begin
      if (accept && (CtrlFunc == FN_CMP)) begin
        flag_q       <= Flags;
        flag_valid_q <= 1'b1;
      end
      if (accept && fn_is_illegal(CtrlFunc)) begin
        illegal_q <= 1'b1;
      end
      if (pop) begin
        retire_q <= retire_q + 1'b1;
      end
    end
  end

  assign FlagReg   = flag_q;
  assign FlagValid = flag_valid_q;
  assign IllegalOp = illegal_q;
  assign RetireCnt = retire_q;

  // Flag value 11 matches none of these, so all conditions read 0.
  assign CondEq = flag_valid_q && (flag_q == FLG_ZERO);
  assign CondLt = flag_valid_q && (flag_q == FLG_NEG);
  assign CondGt = flag_valid_q && (flag_q == FLG_POS);

endmodule
`default_nettype wire

// File: tb/tb_exe_wb_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_exe_wb_stage
// Purpose  : Directed testbench for exe_wb_stage. Expected writebacks are
//            queued when issued; a monitor pops and compares on every
//            register-file handshake.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exe_wb_stage;

  localparam int REG_AW = 4;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              InValid = 1'b0;
  logic              InReady;
  logic [31:0]       Result = '0;
  logic [1:0]        Flags = '0;
  logic [3:0]        CtrlFunc = '0;
  logic [REG_AW-1:0] RdAddr = '0;
  logic              WbValid;
  logic              WbReady = 1'b0;
  logic [REG_AW-1:0] WbAddr;
  logic [31:0]       WbData;
  logic [1:0]        FlagReg;
  logic              FlagValid;
  logic              CondEq;
  logic              CondLt;
  logic              CondGt;
  logic              IllegalOp;
  logic [CNT_W-1:0]  RetireCnt;

  int vectors = 0;
  int miscompares = 0;
  logic [35:0] exp_q[$];

  exe_wb_stage #(
    .REG_AW (REG_AW),
    .CNT_W  (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .InValid   (InValid),
    .InReady   (InReady),
    .Result    (Result),
    .Flags     (Flags),
    .CtrlFunc  (CtrlFunc),
    .RdAddr    (RdAddr),
    .WbValid   (WbValid),
    .WbReady   (WbReady),
    .WbAddr    (WbAddr),
    .WbData    (WbData),
    .FlagReg   (FlagReg),
    .FlagValid (FlagValid),
    .CondEq    (CondEq),
    .CondLt    (CondLt),
    .CondGt    (CondGt),
    .IllegalOp (IllegalOp),
    .RetireCnt (RetireCnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake on the write port must match the queue head.
  always @(negedge clk) begin
    if (WbValid && WbReady) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL wb_unexpected: got addr=%0d data=0x%0h, expected no write", WbAddr, WbData);
      end else begin
        logic [35:0] e;
        e = exp_q.pop_front();
        if ({WbAddr, WbData} !== e) begin
          miscompares++;
          $display("FAIL wb_entry: got addr=%0d data=0x%0h, expected addr=%0d data=0x%0h",
                   WbAddr, WbData, e[35:32], e[31:0]);
        end
      end
    end
  end

  // Presents one op starting at a negedge, waits (bounded) for InReady and
  // returns at the negedge after the accepting edge with InValid dropped.
  task automatic issue(input logic [3:0] fn, input logic [3:0] rd,
                       input logic [31:0] res, input logic [1:0] fl,
                       input bit expect_write);
    int waited;
    if (expect_write) exp_q.push_back({rd, res});
    InValid  = 1'b1;
    CtrlFunc = fn;
    RdAddr   = rd;
    Result   = res;
    Flags    = fl;
    waited   = 0;
    while (!InReady && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!InReady) begin
      vectors++;
      miscompares++;
      $display("FAIL issue_timeout: got InReady=0, expected 1 within 20 cycles");
    end
    @(negedge clk);
    InValid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    // ---- reset state ----
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wbvalid", WbValid, 0);
    chk("rst_inready", InReady, 1);
    chk("rst_wbaddr", WbAddr, 0);
    chk("rst_wbdata", WbData, 0);
    chk("rst_flags", {FlagValid, FlagReg, CondEq, CondLt, CondGt, IllegalOp}, 0);
    chk("rst_retire", RetireCnt, 0);

    // ---- 1: single ADD, 1-cycle latency ----
    WbReady = 1'b1;
    issue(4'b0011, 4'd3, 32'h7, 2'b00, 1);
    chk("add_latency_valid", WbValid, 1);
    @(negedge clk);
    chk("add_retire", RetireCnt, 1);
    chk("add_drained", WbValid, 0);

    // ---- 2: CMP updates flags only ----
    issue(4'b0101, 4'd9, 32'hDEAD, 2'b10, 0);
    chk("cmp_lt", {FlagValid, CondEq, CondLt, CondGt}, 4'b1010);
    chk("cmp_nowrite", WbValid, 0);
    issue(4'b0101, 4'd9, 32'hDEAD, 2'b01, 0);
    chk("cmp_eq", {FlagValid, CondEq, CondLt, CondGt}, 4'b1100);
    issue(4'b0101, 4'd9, 32'hDEAD, 2'b11, 0);
    chk("cmp_11_none", {FlagReg, CondEq, CondLt, CondGt}, 5'b11000);
    chk("cmp_nowrite2", WbValid, 0);

    // ---- 3: backpressure ----
    WbReady = 1'b0;
    issue(4'b0000, 4'd1, 32'hA, 2'b00, 1);
    issue(4'b0001, 4'd2, 32'hB, 2'b00, 1);
    chk("bp_full_inready", InReady, 0);
    chk("bp_head_addr", WbAddr, 1);
    repeat (2) @(negedge clk);
    chk("bp_hold_inready", InReady, 0);
    WbReady = 1'b1;
    issue(4'b0010, 4'd3, 32'hC, 2'b00, 1);
    repeat (3) @(negedge clk);
    chk("bp_retire", RetireCnt, 4);

    // ---- 4: reset discards a buffered write ----
    WbReady = 1'b0;
    issue(4'b0011, 4'd5, 32'hFFFF_FFFF, 2'b00, 0);
    chk("rst_mid_pending", WbValid, 1);
    rst = 1'b1;
    #2 WbReady = 1'b1;
    @(negedge clk);
    chk("rst_mid_masked", WbValid, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_state", {WbValid, InReady, FlagValid}, 3'b010);
    chk("post_rst_retire", RetireCnt, 0);

    // ---- 5: illegal code is sticky ----
    issue(4'b1011, 4'd4, 32'h1234, 2'b01, 0);
    chk("illegal_set", IllegalOp, 1);
    chk("illegal_nopush", WbValid, 0);
    chk("illegal_noflag", FlagValid, 0);
    issue(4'b0011, 4'd2, 32'h5, 2'b00, 1);
    @(negedge clk);
    chk("illegal_sticky", IllegalOp, 1);
    do_reset();
    chk("illegal_cleared", IllegalOp, 0);

    // ---- 6: sustained throughput and counter wrap ----
    for (int i = 0; i < 16; i++) begin
      chk("tput_inready", InReady, 1);
      issue(4'b1000, 4'(i), 32'h100 + 32'(i), 2'b00, 1);
    end
    chk("wrap_15", RetireCnt, 15);
    @(negedge clk);
    chk("wrap_0", RetireCnt, 0);

    // ---- 7: CMP between writes keeps order ----
    issue(4'b0110, 4'd6, 32'h66, 2'b00, 1);
    issue(4'b0101, 4'd0, 32'h0, 2'b00, 0);
    issue(4'b0111, 4'd7, 32'h77, 2'b00, 1);
    repeat (2) @(negedge clk);
    chk("mix_gt", {CondEq, CondLt, CondGt}, 3'b001);
    chk("mix_retire", RetireCnt, 2);

    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/exe_wb_stage.md
# exe_wb_stage

Execute-to-writeback stage placed directly downstream of the 32-bit ALU. Captures each ALU result with its destination register, buffers it in a 2-entry skid FIFO, and presents it to the register-file write port under a valid/ready handshake. Compare operations never write a register. Instead they update an architectural flag register, which drives the branch-condition outputs used by fetch.

## Interface
- `REG_AW`, default 4, register-file address width.
- `CNT_W`, default 16, retire-counter width.

- `clk`  in  1  clock. The block has one clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `InValid`  in  1  ALU output for the current op is valid.
- `InReady`  out  1  stage can accept an op this cycle.
- `Result`  in  32  signed ALU result.
- `Flags`  in  2  ALU flag output. Encoding: 01 = zero, 10 = negative, 00 = positive.
- `CtrlFunc`  in  4  function code of the op whose result is on `Result`.
- `RdAddr`  in  REG_AW  destination register.
- `WbValid`  out  1  writeback entry available.
- `WbReady`  in  1  register file accepts the write.
- `WbAddr`  out  REG_AW  write address.
- `WbData`  out  32  write data.
- `FlagReg`  out  2  architectural flags from the last accepted CMP.
- `FlagValid`  out  1  at least one CMP has been accepted since reset.
- `CondEq`, `CondLt`, `CondGt`  out  1 each  decoded `FlagReg`. All are 0 while `FlagValid` = 0.
- `IllegalOp`  out  1  sticky. Set when a code in the range 1001–1111 is accepted.
- `RetireCnt`  out  CNT_W  count of completed writebacks. Wraps modulo 2^CNT_W.

## Operation
- Accept condition: `InValid & InReady`. Input fields are sampled at that edge.
- Writable codes: 0000–0100 and 0110–1000.
  - On accept, push {`RdAddr`, `Result`} into the FIFO.
- CMP (code 0101):
  - No push.
  - `FlagReg` <= `Flags` and `FlagValid` <= 1.
- Illegal codes (1001–1111):
  - No push and no flag update.
  - `IllegalOp` <= 1. It is cleared only by `rst`.
- FIFO behaviour:
  - Depth is exactly 2, with an occupancy count of 0..2.
  - `InReady` = (count < 2). This is registered-state based and is not combinational from `WbReady`.
  - `WbValid` = (count != 0). `WbAddr`/`WbData` present the head entry.
  - Pop on `WbValid & WbReady`. `RetireCnt` increments by 1 on each pop.
- Occupancy transitions:
  - Push with no pop: +1.
  - Pop with no push: −1.
  - Push and pop together at count 1: count stays 1, and the new entry becomes the head next cycle.
  - Push and pop together at count 0: impossible, since there is no pop without `WbValid`.
- Ordering: strictly FIFO. A CMP accepted between two writes does not reorder or stall them.
- Condition outputs:
  - `CondEq` = `FlagValid` & (`FlagReg` == 01).
  - `CondLt` = `FlagValid` & (`FlagReg` == 10).
  - `CondGt` = `FlagValid` & (`FlagReg` == 00).
  - `FlagReg` == 11 is never produced by the ALU. If loaded, all three conditions are 0.
- Reset values:
  - FIFO count 0, so `WbValid` = 0 and `InReady` = 1 after the reset cycle.
  - `WbAddr` = 0, `WbData` = 0, `FlagReg` = 00, `FlagValid` = 0, `IllegalOp` = 0, `RetireCnt` = 0.
- Reset mid-operation: all buffered entries are discarded without being written. No write is issued in the reset cycle, even if `WbReady` = 1.

## Timing
- Accepted write op: appears on `WbValid`/`WbAddr`/`WbData` in the cycle after the accept edge (1-cycle latency).
- CMP: the `FlagReg` and `Cond*` update is visible in the cycle after the accept edge.
- Backpressure:
  - With `WbReady` held 0, two writes are absorbed.
  - `InReady` falls the cycle after the second accept.
  - `InReady` rises the cycle after the first pop.
- Throughput: one op per cycle sustained while `WbReady` = 1.
- `RetireCnt` wrap: at 2^CNT_W − 1, one more pop gives 0.

## Structure
- Shared package `exe_pkg` holds:
  - The CtrlFunc constants `FN_AND`=0000, `FN_OR`, `FN_XOR`, `FN_ADD`, `FN_SUB`, `FN_CMP`=0101, `FN_NOT`, `FN_SHL16`, `FN_MUL`=1000.
  - The flag encodings `FLG_POS`=00, `FLG_ZERO`=01, `FLG_NEG`=10.
  - The `wb_entry_t` struct {addr, data}.
- Sub-module `wb_skid_fifo`: a 2-entry, parameterised-width FIFO with push/pop/count. `exe_wb_stage` instantiates it once. Decode, flag logic and counters stay at the top level.

## Test plan
1. Reset, then an ADD (`Result`=0x0000_0007, `RdAddr`=3) with `WbReady`=1 → next cycle `WbValid`=1, `WbAddr`=3, `WbData`=7. `RetireCnt`=1 after the pop.
2. CMP with `Flags`=10, then CMP with `Flags`=01 → `CondLt`=1 after the first and `CondEq`=1 after the second. `WbValid` stays 0 throughout.
3. `WbReady`=0, three back-to-back writes (r1=0xA, r2=0xB, r3=0xC) → `InReady` low after the second. The third is held off until `WbReady`=1, then writes retire in order r1, r2, r3.
4. `Result`=0xFFFF_FFFF to r5, then `rst` asserted while `WbReady`=0 → no write occurs. Post-reset: `WbValid`=0, `InReady`=1, `FlagValid`=0, `RetireCnt`=0.
5. CtrlFunc=1011 accepted → no push, `IllegalOp`=1. It stays 1 across later legal ops until `rst`.
6. `CNT_W`=4, 16 pops → `RetireCnt` returns to 0.
